// File: rtl/bcd_addsub_serial_if.sv
// Start/done request bundle for the digit-serial BCD add/subtract unit.
// master drives operands and start; slave returns status and result.
interface bcd_addsub_serial_if #(
  parameter int DIGITS = 3
);
  logic                  start;
  logic                  sub;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   result;
  logic                  negative;
  logic                  overflow;
  logic                  err;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, negative, overflow, err
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, negative, overflow, err
  );
endinterface

// File: rtl/bcd_addsub_serial.sv
// Digit-serial BCD add/subtract, LSD first, sign+magnitude via complement pass.
// Optional input digit check enabled by macro BCD_INPUT_CHECK_EN.
module bcd_addsub_serial #(
  parameter int DIGITS = 3
) (
  input logic            clk,
  input logic            rst,
  bcd_addsub_serial_if.slave io
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, COMP, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q;
  logic [W-1:0]    a_q, b_q, raw_q, result_q;
  logic            sub_q, c_q;
  logic            negative_q, overflow_q;

  logic [3:0]      op_x, op_y, dig;
  logic            do_sub, cout, last;
  logic [4:0]      sum5, sum_adj, dif5, dif_adj;
  logic [W+3:0]    cat;
  logic [W-1:0]    nxt_raw;

`ifdef BCD_INPUT_CHECK_EN
  logic            bad_q, err_q;

  function automatic logic has_bad(input logic [W-1:0] v);
    has_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) has_bad = 1'b1;
  endfunction
`endif

  // One BCD digit step; COMP pass reuses the subtractor as 0 - raw.
  always_comb begin
    do_sub  = sub_q | (state_q == COMP);
    op_x    = (state_q == COMP) ? 4'd0 : a_q[3:0];
    op_y    = (state_q == COMP) ? raw_q[3:0] : b_q[3:0];
    sum5    = {1'b0, op_x} + {1'b0, op_y} + {4'd0, c_q};
    sum_adj = sum5 + 5'd6;
    dif5    = {1'b0, op_x} - {1'b0, op_y} - {4'd0, c_q};
    dif_adj = dif5 + 5'd10;
    if (do_sub) begin
      cout = dif5[4];
      dig  = dif5[4] ? dif_adj[3:0] : dif5[3:0];
    end else begin
      cout = (sum5 > 5'd9);
      dig  = cout ? sum_adj[3:0] : sum5[3:0];
    end
    cat     = {dig, raw_q};
    nxt_raw = cat[W+3:4];
    last    = (idx_q == IW'(DIGITS - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (io.start) state_d = CALC;
      CALC: begin
        if (last) state_d = (sub_q && cout) ? COMP : DONE;
`ifdef BCD_INPUT_CHECK_EN
        if (bad_q) state_d = DONE;
`endif
      end
      COMP: if (last) state_d = DONE;
      DONE: state_d = io.start ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs and held result registers.
  always_comb begin
    io.busy     = (state_q == CALC) || (state_q == COMP);
    io.done     = (state_q == DONE);
    io.result   = result_q;
    io.negative = negative_q;
    io.overflow = overflow_q;
`ifdef BCD_INPUT_CHECK_EN
    io.err      = err_q;
`else
    io.err      = 1'b0;
`endif
  end

  // Operand latch, digit shifting and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      raw_q      <= '0;
      result_q   <= '0;
      sub_q      <= 1'b0;
      c_q        <= 1'b0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
`ifdef BCD_INPUT_CHECK_EN
      bad_q      <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (io.start) begin
            a_q        <= io.a;
            b_q        <= io.b;
            sub_q      <= io.sub;
            c_q        <= 1'b0;
            idx_q      <= '0;
            raw_q      <= '0;
            result_q   <= '0;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
`ifdef BCD_INPUT_CHECK_EN
            bad_q      <= has_bad(io.a) | has_bad(io.b);
            err_q      <= 1'b0;
`endif
          end
        end
        CALC: begin
          raw_q <= nxt_raw;
          a_q   <= a_q >> 4;
          b_q   <= b_q >> 4;
          c_q   <= cout;
          idx_q <= last ? '0 : idx_q + 1'b1;
          if (last) begin
            if (sub_q && cout) begin
              c_q <= 1'b0;
            end else begin
              result_q   <= nxt_raw;
              overflow_q <= ~sub_q & cout;
            end
          end
`ifdef BCD_INPUT_CHECK_EN
          if (bad_q) begin
            err_q      <= 1'b1;
            result_q   <= '0;
            overflow_q <= 1'b0;
            negative_q <= 1'b0;
          end
`endif
        end
        COMP: begin
          raw_q <= nxt_raw;
          c_q   <= cout;
          idx_q <= last ? '0 : idx_q + 1'b1;
          if (last) begin
            result_q   <= nxt_raw;
            negative_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Self-checking bench for bcd_addsub_serial (DIGITS=3).
// Latency counts rising edges from the start-sampling edge to done.
module tb_bcd_addsub_serial;
  localparam int D = 3;
  localparam int W = 4 * D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  bcd_addsub_serial_if #(.DIGITS(D)) io ();

  bcd_addsub_serial #(.DIGITS(D)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] res;
    logic         neg;
    logic         ovf;
    int           lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic s, output int lat, output bit ok);
    @(negedge clk);
    io.start = 1'b1;
    io.a     = a;
    io.b     = b;
    io.sub   = s;
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      io.start = 1'b0;
      if (io.done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    bit ok;
    int ndone;
    int first;

    vecs[0] = '{12'h123, 12'h045, 1'b1, 12'h078, 1'b0, 1'b0, 4};
    vecs[1] = '{12'h045, 12'h123, 1'b1, 12'h078, 1'b1, 1'b0, 7};
    vecs[2] = '{12'h999, 12'h001, 1'b0, 12'h000, 1'b0, 1'b1, 4};
    vecs[3] = '{12'h456, 12'h123, 1'b0, 12'h579, 1'b0, 1'b0, 4};
    vecs[4] = '{12'h500, 12'h500, 1'b1, 12'h000, 1'b0, 1'b0, 4};
    vecs[5] = '{12'h000, 12'h001, 1'b1, 12'h001, 1'b1, 1'b0, 7};
    vecs[6] = '{12'h999, 12'h999, 1'b0, 12'h998, 1'b0, 1'b1, 4};
    vecs[7] = '{12'h100, 12'h099, 1'b1, 12'h001, 1'b0, 1'b0, 4};
    vecs[8] = '{12'h058, 12'h047, 1'b0, 12'h105, 1'b0, 1'b0, 4};

    io.start = 1'b0;
    io.sub   = 1'b0;
    io.a     = '0;
    io.b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(io.busy), 0);
    check("rst_done", int'(io.done), 0);
    check("rst_result", int'(io.result), 0);
    check("rst_neg", int'(io.negative), 0);
    check("rst_ovf", int'(io.overflow), 0);
    check("rst_err", int'(io.err), 0);
    rst = 1'b0;

    for (int k = 0; k < 9; k++) begin
      run(vecs[k].a, vecs[k].b, vecs[k].sub, lat, ok);
      check($sformatf("v%0d_done_seen", k), int'(ok), 1);
      check($sformatf("v%0d_latency", k), lat, vecs[k].lat);
      check($sformatf("v%0d_result", k), int'(io.result), int'(vecs[k].res));
      check($sformatf("v%0d_negative", k), int'(io.negative), int'(vecs[k].neg));
      check($sformatf("v%0d_overflow", k), int'(io.overflow), int'(vecs[k].ovf));
      check($sformatf("v%0d_err", k), int'(io.err), 0);
      @(negedge clk);
      check($sformatf("v%0d_done_1cyc", k), int'(io.done), 0);
      @(negedge clk);
      check($sformatf("v%0d_hold", k), int'(io.result), int'(vecs[k].res));
    end

    // start pulses while busy must not disturb the operation in flight
    @(negedge clk);
    io.start = 1'b1;
    io.a = 12'h045;
    io.b = 12'h123;
    io.sub = 1'b1;
    ndone = 0;
    first = 0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i <= 3) begin
        io.start = 1'b1;
        io.a = 12'h111;
        io.b = 12'h222;
        io.sub = 1'b0;
      end else begin
        io.start = 1'b0;
      end
      if (io.done) begin
        ndone++;
        if (first == 0) begin
          first = i;
          check("busy_start_result", int'(io.result), 12'h078);
          check("busy_start_neg", int'(io.negative), 1);
        end
      end
    end
    check("busy_start_latency", first, 7);
    check("busy_start_ndone", ndone, 1);

    // reset two clocks into a negative subtraction
    @(negedge clk);
    io.start = 1'b1;
    io.a = 12'h045;
    io.b = 12'h123;
    io.sub = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", int'(io.busy), 0);
    check("abort_done", int'(io.done), 0);
    check("abort_result", int'(io.result), 0);
    check("abort_neg", int'(io.negative), 0);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (io.done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run(12'h456, 12'h123, 1'b0, lat, ok);
    check("after_abort_done", int'(ok), 1);
    check("after_abort_lat", lat, 4);
    check("after_abort_result", int'(io.result), 12'h579);

`ifdef BCD_INPUT_CHECK_EN
    run(12'h1A3, 12'h000, 1'b0, lat, ok);
    check("bad_done", int'(ok), 1);
    check("bad_latency", lat, 2);
    check("bad_err", int'(io.err), 1);
    check("bad_result", int'(io.result), 0);
    check("bad_ovf", int'(io.overflow), 0);
`else
    run(12'h1A3, 12'h000, 1'b0, lat, ok);
    check("nochk_done", int'(ok), 1);
    check("nochk_latency", lat, 4);
    check("nochk_err", int'(io.err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
